router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
- REQ-001: clock  input  1  system clock; all state changes on rising edge.
- REQ-002: reset  input  1  asynchronous, active-high reset.
- REQ-003: soft_reset  input  1  synchronous per-FIFO flush, driven by the synchronizer's read timeout.
- REQ-004: write_enb  input  1  write request, one bit of the synchronizer's write_enb bus.
- REQ-005: read_enb  input  1  read request from the destination port.
- REQ-006: lfd_state  input  1  marks data_in as the packet header byte.
- REQ-007: data_in  input  8  packet byte.
- REQ-008: data_out  output  8  registered read data.
- REQ-009: full  output  1  FIFO holds 16 words; feeds the synchronizer's full_x input.
- REQ-010: empty  output  1  FIFO holds 0 words; feeds the synchronizer's empty_x input.

Function
- REQ-011: Storage SHALL be 16 words x 9 bits, with word = {lfd_state, data_in}.
- REQ-012: Write SHALL occur when write_enb=1 and full=0; the word is stored at wr_ptr and wr_ptr advances by 1.
- REQ-013: Read SHALL occur when read_enb=1 and empty=0; data_out <= word[7:0] at that edge (1-cycle latency) and rd_ptr advances by 1.
- REQ-014: wr_ptr and rd_ptr SHALL be 5 bits; the low 4 bits address memory, and bit 4 is the wrap bit.
- REQ-015: empty SHALL be 1 when wr_ptr==rd_ptr; full SHALL be 1 when the pointer bits [3:0] are equal and bit 4 differs; both are combinational from the pointers.
- REQ-016: Write ignored when full=1, read ignored when empty=1; in both cases pointers, memory and counter are unchanged.
- REQ-017: Simultaneous valid read and write SHALL both execute; occupancy is unchanged.
- REQ-018: Full with both read_enb and write_enb high: only the read executes, and full deasserts next cycle.
- REQ-019: Empty with both read_enb and write_enb high: only the write executes.
- REQ-020: A 6-bit packet counter SHALL load word[7:2]+1 (payload length plus parity) on a read of a word with bit 8=1.
- REQ-021: On any other valid read, the counter SHALL decrement by 1 if nonzero.
- REQ-022: When the counter is 0 and no valid read occurs in that cycle, data_out SHALL go to its idle value (see REQ-030).
- REQ-023: The counter SHALL saturate at 0, never wrapping to 63.

Reset
- REQ-024: reset=1 SHALL asynchronously clear wr_ptr, rd_ptr and the counter, set data_out=8'h00, empty=1, full=0.
- REQ-025: Memory contents are not cleared by reset.
- REQ-026: soft_reset=1 at a clock edge SHALL clear pointers and counter and set data_out to its idle value.
- REQ-027: soft_reset SHALL take priority over a same-cycle read or write.
- REQ-028: Reset deasserted mid-packet SHALL leave the FIFO empty; stale words are never presented.

Configuration
- REQ-029: Macro ROUTER_FIFO_HIZ_EN selects the data_out idle value.
- REQ-030: With ROUTER_FIFO_HIZ_EN defined, idle data_out SHALL be 8'bz (shared-bus style); without it, idle data_out SHALL be 8'h00.
- REQ-031: The reset value of data_out SHALL be 8'h00 in both builds.

Structure
- REQ-032: Package router_pkg SHALL hold DATA_W=8, FIFO_DEPTH=16, PTR_W=5, and the word type (9-bit header-flag + data).
- REQ-033: The storage array SHALL be the sub-module router_fifo_mem: 16x9, one synchronous write port, one read port.
- REQ-034: Pointers, flags, counter and output register SHALL reside in router_fifo.

Verification
- REQ-035: Reset scenario: reset pulse -> empty=1, full=0, data_out=8'h00; a read attempt leaves empty=1.
- REQ-036: Fill scenario: write 16 words with read_enb=0 -> full=1 after the 16th edge; a 17th write leaves the pointers unchanged.
- REQ-037: Packet scenario: write header 8'h0C with lfd_state=1, then 3 payload bytes, then parity; read 5 -> data_out sequence 0C, payload, parity; counter goes 4,3,2,1,0; next idle cycle gives data_out 8'h00, or Z with ROUTER_FIFO_HIZ_EN.
- REQ-038: Concurrency scenario: with 8 words stored, assert read_enb and write_enb together for 4 cycles -> occupancy stays 8 and read order is preserved.
- REQ-039: Soft reset scenario: with 5 words stored, assert soft_reset for 1 cycle -> empty=1 next cycle, data_out at idle value, and the following write/read returns the new data.
- REQ-040: Wrap scenario: 40 interleaved writes/reads crossing the wrap bit twice -> no false full/empty, and data matches a reference queue.

Source files
------------

// File: rtl/router_pkg.sv
// Shared widths and word type for the router output FIFO.
// A stored word is the header flag followed by the packet byte.
package router_pkg;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = 5;
    localparam int ADDR_W     = PTR_W - 1;
    localparam int CNT_W      = DATA_W - 2;
    localparam int WORD_W     = DATA_W + 1;

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    // Header byte carries payload length in [7:2]; one extra byte for parity.
    function automatic logic [CNT_W-1:0] pkt_count(input fifo_word_t w);
        return w.data[DATA_W-1:2] + CNT_W'(1);
    endfunction
endpackage

// File: rtl/router_fifo_mem.sv
// 16 x 9 storage for router_fifo: synchronous write, asynchronous read.
// The output register lives in router_fifo, so the read port stays combinational.
module router_fifo_mem
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_word
);
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

    // No reset: contents survive reset and are fenced off by the pointers.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem_q[rd_addr];
endmodule

// File: rtl/router_fifo.sv
// Router output FIFO: 16-deep packet buffer with header-driven byte counter.
// Define ROUTER_FIFO_HIZ_EN to float data_out when idle instead of driving 8'h00.
module router_fifo
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              do_wr, do_rd;
    logic [WORD_W-1:0] rd_raw;
    fifo_word_t        rd_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);

    // A flush wins over any same-cycle transfer, including the memory write.
    assign do_wr = write_enb && !full  && !soft_reset;
    assign do_rd = read_enb  && !empty && !soft_reset;

    router_fifo_mem u_mem (
        .clock   (clock),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_word ({lfd_state, data_in}),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_word (rd_raw)
    );

    assign rd_word = fifo_word_t'(rd_raw);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        if (soft_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            oe_d     = 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                dout_d   = rd_word.data;
                oe_d     = 1'b1;
                if (rd_word.hdr) begin
                    cnt_d = pkt_count(rd_word);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (cnt_q == '0) begin
                // Packet fully delivered: release the output to its idle value.
                oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
        end
    end

`ifdef ROUTER_FIFO_HIZ_EN
    assign data_out = oe_q ? dout_q : {DATA_W{1'bz}};
`else
    assign data_out = oe_q ? dout_q : '0;
`endif
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo (default build, idle data_out = 8'h00).
// A vector table covers packet/counter/soft-reset cases; loops cover fill, concurrency, wrap.
module tb_router_fifo;
    logic       clock = 1'b0;
    logic       reset, soft_reset, write_enb, read_enb, lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full, empty;

    int n_tests = 0;
    int n_fail  = 0;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       sr, wr, rd, lfd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       full, empty;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic sr, input logic wr, input logic rd, input logic lfd,
                                input logic [7:0] din, input logic [7:0] dout,
                                input logic fl, input logic em);
        vec_t v;
        v.sr = sr; v.wr = wr; v.rd = rd; v.lfd = lfd;
        v.din = din; v.dout = dout; v.full = fl; v.empty = em;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic sr, input logic wr, input logic rd, input logic lfd,
                       input logic [7:0] din);
        soft_reset = sr; write_enb = wr; read_enb = rd; lfd_state = lfd; data_in = din;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_flags(input string name, input logic ef, input logic ee);
        chk({name, ".full"}, {7'd0, full}, {7'd0, ef});
        chk({name, ".empty"}, {7'd0, empty}, {7'd0, ee});
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_d;

    initial begin
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        lfd_state = 1'b0; data_in = 8'h00;
        @(posedge clock); @(posedge clock); #1;
        chk("reset.dout", data_out, 8'h00);
        chk_flags("reset", 1'b0, 1'b1);
        reset = 1'b0;

        // ---- vector table ----
        add(0,0,1,0,8'h00, 8'h00,0,1);   // read attempt on empty
        add(0,1,0,1,8'h0C, 8'h00,0,0);   // header, length 3
        add(0,1,0,0,8'h11, 8'h00,0,0);
        add(0,1,0,0,8'h22, 8'h00,0,0);
        add(0,1,0,0,8'h33, 8'h00,0,0);
        add(0,1,0,0,8'hA5, 8'h00,0,0);   // parity
        add(0,0,1,0,8'h00, 8'h0C,0,0);   // counter -> 4
        add(0,0,1,0,8'h00, 8'h11,0,0);   // 3
        add(0,0,0,0,8'h00, 8'h11,0,0);   // counter nonzero: hold
        add(0,0,1,0,8'h00, 8'h22,0,0);   // 2
        add(0,0,1,0,8'h00, 8'h33,0,0);   // 1
        add(0,0,1,0,8'h00, 8'hA5,0,1);   // 0
        add(0,0,0,0,8'h00, 8'h00,0,1);   // idle
        add(0,1,0,1,8'h01, 8'h00,0,0);   // header, length 0 -> count 1
        add(0,1,0,0,8'h5A, 8'h00,0,0);
        add(0,0,1,0,8'h00, 8'h01,0,0);
        add(0,0,0,0,8'h00, 8'h01,0,0);   // hold
        add(0,0,1,0,8'h00, 8'h5A,0,1);   // counter -> 0
        add(0,0,0,0,8'h00, 8'h00,0,1);
        add(0,1,1,0,8'h3C, 8'h00,0,0);   // empty + both: write only
        add(0,0,1,0,8'h00, 8'h3C,0,1);
        add(0,1,0,1,8'h10, 8'h00,0,0);   // header, length 4 -> count 5
        add(0,1,0,0,8'h20, 8'h00,0,0);
        add(0,1,0,0,8'h30, 8'h00,0,0);
        add(0,1,0,0,8'h40, 8'h00,0,0);
        add(0,1,0,0,8'h50, 8'h00,0,0);
        add(0,1,0,0,8'h60, 8'h00,0,0);
        add(0,0,1,0,8'h00, 8'h10,0,0);   // 5 words remain
        add(1,1,1,0,8'h99, 8'h00,0,1);   // soft reset beats read and write
        add(0,1,0,0,8'h77, 8'h00,0,0);
        add(0,0,1,0,8'h00, 8'h77,0,1);

        foreach (vecs[i]) begin
            cyc(vecs[i].sr, vecs[i].wr, vecs[i].rd, vecs[i].lfd, vecs[i].din);
            $display("[TB] vec %0d sr=%b wr=%b rd=%b din=%h -> dout=%h full=%b empty=%b",
                     i, vecs[i].sr, vecs[i].wr, vecs[i].rd, vecs[i].din, data_out, full, empty);
            chk($sformatf("vec%0d.dout", i), data_out, vecs[i].dout);
            chk_flags($sformatf("vec%0d", i), vecs[i].full, vecs[i].empty);
        end

        // ---- fill to 16, blocked 17th write, full with read+write ----
        for (int i = 0; i < 16; i++) begin
            cyc(0,1,0,0,8'h40 + 8'(i));
            chk_flags($sformatf("fill%0d", i), (i == 15), 1'b0);
        end
        $display("[TB] fill done full=%b", full);
        cyc(0,1,0,0,8'hFF);
        chk_flags("fill17", 1'b1, 1'b0);
        cyc(0,1,1,0,8'hEE);
        chk("fullrw.dout", data_out, 8'h40);
        chk_flags("fullrw", 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            cyc(0,0,1,0,8'h00);
            chk($sformatf("drain%0d.dout", i), data_out, 8'h40 + 8'(i));
        end
        chk_flags("drained", 1'b0, 1'b1);

        // ---- concurrent read/write at occupancy 8 ----
        for (int i = 0; i < 8; i++) cyc(0,1,0,0,8'h80 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            cyc(0,1,1,0,8'h90 + 8'(i));
            $display("[TB] conc %0d dout=%h", i, data_out);
            chk($sformatf("conc%0d.dout", i), data_out, 8'h80 + 8'(i));
            chk_flags($sformatf("conc%0d", i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0,0,1,0,8'h00);
            chk($sformatf("concdrain%0d", i), data_out,
                (i < 4) ? 8'h84 + 8'(i) : 8'h90 + 8'(i - 4));
        end
        chk_flags("concdone", 1'b0, 1'b1);

        // ---- 40 interleaved operations across the wrap bit, reference queue ----
        q.delete();
        for (int i = 0; i < 56; i++) begin
            logic wr, rd, wr_ok, rd_ok;
            logic [7:0] d;
            wr = (i < 40) && (i % 7 != 6);
            rd = (i >= 4) && (i % 5 != 0);
            d  = 8'((i * 37 + 11) & 255);
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && (q.size() < 16);
            exp_d = rd_ok ? q.pop_front() : 8'h00;
            if (wr_ok) q.push_back(d);
            cyc(0, wr, rd, 0, d);
            $display("[TB] wrap %0d wr=%b rd=%b dout=%h occ=%0d", i, wr, rd, data_out, q.size());
            chk($sformatf("wrap%0d.dout", i), data_out, exp_d);
            chk_flags($sformatf("wrap%0d", i), (q.size() == 16), (q.size() == 0));
        end

        // ---- asynchronous reset mid-packet ----
        cyc(0,1,0,1,8'h0C);
        cyc(0,1,0,0,8'hC1);
        cyc(0,1,0,0,8'hC2);
        cyc(0,0,1,0,8'h00);
        chk("prerst.dout", data_out, 8'h0C);
        read_enb = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst.dout", data_out, 8'h00);
        chk_flags("arst", 1'b0, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0;
        cyc(0,0,1,0,8'h00);
        $display("[TB] post-reset read dout=%h empty=%b", data_out, empty);
        chk("postrst.dout", data_out, 8'h00);
        chk_flags("postrst", 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
